// File: rtl/frame_streamer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_streamer_pkg                                                    |
// | Shared defaults, framing constants and FSM encoding for the streamer. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package frame_streamer_pkg;

    localparam int DEF_O_BW       = 14;
    localparam int DEF_TOTAL_DATA = 91136;
    localparam int DEF_FRAME_LEN  = 512;
    localparam int DEF_HOP        = 256;
    localparam int DEF_NUM_FRAMES = 355;
    localparam int DEF_GAP        = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_GAP   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Counter width that never collapses to zero bits.
    function automatic int min1_clog2(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_addr_gen                                                        |
// | Frame base / in-frame offset / frame index counters and end flags.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module frame_addr_gen
    import frame_streamer_pkg::*;
#(
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int HOP        = DEF_HOP,
    parameter int NUM_FRAMES = DEF_NUM_FRAMES,
    parameter int TOTAL_DATA = DEF_TOTAL_DATA
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                load,
    input  logic                                step,
    input  logic                                next_frame,
    output logic [$clog2(TOTAL_DATA)-1:0]       addr,
    output logic [$clog2(FRAME_LEN)-1:0]        off,
    output logic [min1_clog2(NUM_FRAMES)-1:0]   frame_idx,
    output logic                                last_sample,
    output logic                                last_frame
);

    localparam int AW = $clog2(TOTAL_DATA);
    localparam int NW = $clog2(FRAME_LEN);
    localparam int FW = min1_clog2(NUM_FRAMES);

    logic [AW-1:0] base;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base      <= '0;
            off       <= '0;
            frame_idx <= '0;
        end else if (load) begin
            base      <= '0;
            off       <= '0;
            frame_idx <= '0;
        end else if (next_frame) begin
            base      <= base + AW'(HOP);
            off       <= '0;
            frame_idx <= frame_idx + 1'b1;
        end else if (step) begin
            off <= off + 1'b1;
        end
    end

    assign addr        = base + AW'(off);
    assign last_sample = (off == NW'(FRAME_LEN - 1));
    assign last_frame  = (frame_idx == FW'(NUM_FRAMES - 1));

endmodule
`default_nettype wire

// File: rtl/frame_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_streamer                                                        |
// | Reads sample RAM and emits overlapping frames with markers and index. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module frame_streamer
    import frame_streamer_pkg::*;
#(
    parameter int O_BW       = DEF_O_BW,
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int HOP        = DEF_HOP,
    parameter int NUM_FRAMES = DEF_NUM_FRAMES,
    parameter int GAP        = DEF_GAP,
    parameter int TOTAL_DATA = DEF_TOTAL_DATA
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                mem_rd,
    output logic [$clog2(TOTAL_DATA)-1:0]       mem_addr,
    input  logic [O_BW-1:0]                     mem_re,
    input  logic [O_BW-1:0]                     mem_im,
    output logic                                do_en,
    output logic [O_BW-1:0]                     do_re,
    output logic [O_BW-1:0]                     do_im,
    output logic                                do_sof,
    output logic                                do_eof,
    output logic [$clog2(FRAME_LEN)-1:0]        num,
    output logic [min1_clog2(NUM_FRAMES)-1:0]   frame_idx,
    output logic                                busy,
    output logic                                done
);

    localparam int AW = $clog2(TOTAL_DATA);
    localparam int NW = $clog2(FRAME_LEN);
    localparam int FW = min1_clog2(NUM_FRAMES);
    localparam int GW = min1_clog2(GAP);

    state_t          state, state_nx;
    logic            load, step, next_frame;
    logic            last_sample, last_frame, gap_last;
    logic [AW-1:0]   addr;
    logic [NW-1:0]   off;
    logic [FW-1:0]   fidx;
    logic [GW-1:0]   gap_cnt;
    logic [O_BW-1:0] re_hold, im_hold;

    frame_addr_gen #(
        .FRAME_LEN  (FRAME_LEN),
        .HOP        (HOP),
        .NUM_FRAMES (NUM_FRAMES),
        .TOTAL_DATA (TOTAL_DATA)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .step        (step),
        .next_frame  (next_frame),
        .addr        (addr),
        .off         (off),
        .frame_idx   (fidx),
        .last_sample (last_sample),
        .last_frame  (last_frame)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    // A start coinciding with the done pulse is dropped.
    always_comb begin
        state_nx   = state;
        load       = 1'b0;
        step       = 1'b0;
        next_frame = 1'b0;
        mem_rd     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !done) begin
                    load     = 1'b1;
                    state_nx = ST_READ;
                end
            end
            ST_READ: begin
                mem_rd = 1'b1;
                if (!last_sample) begin
                    step = 1'b1;
                end else if (last_frame) begin
                    state_nx = ST_DRAIN;
                end else begin
                    next_frame = 1'b1;
                    state_nx   = (GAP == 0) ? ST_READ : ST_GAP;
                end
            end
            ST_GAP:   if (gap_last) state_nx = ST_READ;
            ST_DRAIN: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 gap_cnt <= '0;
        else if (state == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
        else                      gap_cnt <= '0;
    end

    assign gap_last = (int'(gap_cnt) >= GAP - 1);
    assign busy     = (state != ST_IDLE);
    assign mem_addr = addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            do_en     <= 1'b0;
            do_sof    <= 1'b0;
            do_eof    <= 1'b0;
            num       <= '0;
            frame_idx <= '0;
            done      <= 1'b0;
            re_hold   <= '0;
            im_hold   <= '0;
        end else begin
            do_en  <= mem_rd;
            do_sof <= mem_rd && (off == '0);
            do_eof <= mem_rd && last_sample;
            done   <= (state == ST_DRAIN);
            if (mem_rd) begin
                num       <= off;
                frame_idx <= fidx;
            end
            if (do_en) begin
                re_hold <= mem_re;
                im_hold <= mem_im;
            end
        end
    end

    // RAM data arrives with do_en, so it passes straight through and is held between frames.
    assign do_re = do_en ? mem_re : re_hold;
    assign do_im = do_en ? mem_im : im_hold;

endmodule
`default_nettype wire

// File: doc/frame_streamer.md
# frame_streamer

Transmit-side source for the complex sample stream consumed by the stream counter. It reads samples from a synchronous-read sample RAM and emits them as overlapping analysis frames on a `do_en`/`do_re`/`do_im` stream, ahead of windowing and FFT. It also provides per-frame markers and a sample index.

## Interface
Parameters:
- `O_BW`, 14, sample width of the real and imaginary parts.
- `FRAME_LEN`, 512, samples per frame; must be at least 2.
- `HOP`, 256, start-address step between frames; 1 ≤ `HOP` ≤ `FRAME_LEN`.
- `NUM_FRAMES`, 355, frames per run; must be at least 1.
- `GAP`, 4, idle cycles between consecutive frames; 0 is allowed.
- `TOTAL_DATA`, 91136, RAM depth; must be at least (`NUM_FRAMES`-1)*`HOP`+`FRAME_LEN`.

Ports:
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle run request; ignored unless the block is IDLE.
- `mem_rd` out 1: RAM read strobe.
- `mem_addr` out `$clog2(TOTAL_DATA)`: RAM read address.
- `mem_re`, `mem_im` in `O_BW`: RAM read data; valid the cycle after `mem_rd`.
- `do_en` out 1: output sample valid.
- `do_re`, `do_im` out `O_BW`: output sample.
- `do_sof`, `do_eof` out 1: first and last sample of a frame; qualified by `do_en`.
- `num` out `$clog2(FRAME_LEN)`: zero-based sample index within the frame.
- `frame_idx` out `$clog2(NUM_FRAMES)` (minimum 1 bit): current frame number.
- `busy` out 1: high from the cycle after `start` is accepted until the last sample is emitted.
- `done` out 1: one-cycle pulse, the cycle after the final `do_en`.

## Operation
- Reset values: every output is 0; the FSM is in IDLE.
- FSM states: IDLE, READ, GAP, DRAIN.
  - IDLE to READ when `start` is high. This loads `base` = 0, `off` = 0, `frame_idx` = 0.
  - READ: assert `mem_rd` with `mem_addr` = `base`+`off`, then increment `off`.
    - At `off` = `FRAME_LEN`-1 on a frame that is not the last: go to GAP, or directly to READ of the next frame if `GAP` = 0. On that transition set `base` += `HOP`, `off` = 0, `frame_idx` += 1.
    - At `off` = `FRAME_LEN`-1 on the last frame: go to DRAIN.
  - GAP: count `GAP` cycles with `mem_rd` = 0, then go to READ.
  - DRAIN: wait one cycle for the final read data, pulse `done`, then go to IDLE.
- Output stage: one pipeline register fed from the RAM data.
  - `do_en` is `mem_rd` delayed by one cycle.
  - `do_re`/`do_im` take `mem_re`/`mem_im` when the delayed strobe is high, and hold their value otherwise.
  - `num`, `do_sof` (`num` = 0), `do_eof` (`num` = `FRAME_LEN`-1) and the output-side `frame_idx` are pipelined alongside `do_en` so they stay aligned with the data.
- Address arithmetic is unsigned. Frames overlap by `FRAME_LEN`-`HOP` samples, so those addresses are re-read.
- `start` while `busy` has no effect. Reset mid-run aborts immediately; no `done` pulse is produced.

## Timing
- Let cycle 0 be the edge at which `start` is sampled.
  - `mem_rd` is high from cycle 1.
  - First `do_en` is in cycle 2.
  - Latency from `mem_rd` to `do_en` is exactly 1 cycle.
- Within a frame, `do_en` is continuous for `FRAME_LEN` cycles.
- Between frames, `do_en` is low for exactly `GAP` cycles.
- The final `do_en` is in cycle 1 + `NUM_FRAMES`*`FRAME_LEN` + (`NUM_FRAMES`-1)*`GAP`. `done` is high in the following cycle.
- `busy` rises in cycle 1 and falls together with the `done` pulse.
- A `start` pulse in the same cycle as `done` is ignored. A `start` pulse in any later cycle is accepted.

## Structure
- Shared package holds:
  - default widths (`O_BW` = 14, `TOTAL_DATA` = 91136);
  - the framing constants (`FRAME_LEN`, `HOP`, `NUM_FRAMES`);
  - the FSM state encoding.
- Sub-module `frame_addr_gen` holds the `base`/`off`/`frame_idx` counters and the last-sample and last-frame flags.
- The top level contains the FSM, the GAP counter and the output pipeline.

## Test plan
All scenarios use a RAM model with `mem_re` = address and `mem_im` = 1000 + address, and small parameters `FRAME_LEN`=4, `HOP`=2, `NUM_FRAMES`=3, `GAP`=1.
- Single run: `start` in cycle 0 → `do_re` sequence 0,1,2,3, _,2,3,4,5, _,4,5,6,7.
  - `num` runs 0..3 in each frame.
  - `do_sof` on samples 0, 2, 4; `do_eof` on samples 3, 5, 7.
  - `frame_idx` is 0, 1, 2.
  - `done` in cycle 16.
- Same run with `GAP`=0 → 12 consecutive `do_en` cycles and `done` in cycle 14.
- `start` repeated at cycles 3 and 8 while busy → output identical to the single-run case.
- Reset asserted at cycle 6 → all outputs 0 immediately and no `done`. A fresh `start` afterwards reproduces the single-run case exactly.
- `HOP`=`FRAME_LEN`=4 → addresses 0..11 are read exactly once each. `do_im` is 1000..1011.
- Back-to-back runs: second `start` in the cycle after `done` → the second run is identical in timing relative to its own `start`.
